aes_block_packer: RTL and testbench

Input-side width adapter of the AES HWPE, placed between the streamer's 32-bit `aes_input` source and the 128-bit cipher datapath inside the engine. It gathers four consecutive 32-bit stream beats into one 128-bit AES state block in FIPS-197 byte order. It presents each block on a valid/ready port and counts blocks against a job length programmed by the controller. When the job completes it raises a one-cycle done pulse.

---
 rtl/aes_block_packer_pkg.sv | 28 ++
 rtl/hwpe_stream_intf_stream.sv | 13 +
 rtl/aes_block_packer.sv | 96 +++++++++
 tb/tb_aes_block_packer.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_block_packer_pkg.sv
// Shared types for the AES input packer: controller/flag structs, block geometry and FSM states.
package aes_block_packer_pkg;

  // Block-count width is fixed here because the ctrl/flags structs carry it.
  localparam int unsigned N_BLK_W   = 16;
  localparam int unsigned AES_BLK_W = 128;
  localparam int unsigned AES_WORDS = 4;

  typedef struct packed {
    logic               start;
    logic [N_BLK_W-1:0] len_blocks;
  } ctrl_packer_t;

  typedef struct packed {
    logic               busy;
    logic               done;
    logic               err_strb;
    logic [N_BLK_W-1:0] blk_cnt;
  } flags_packer_t;

  typedef enum logic [1:0] {
    PK_IDLE,
    PK_FILL,
    PK_HOLD,
    PK_DONE
  } packer_state_t;

endpackage

// File: rtl/hwpe_stream_intf_stream.sv
// Minimal HWPE word stream: valid/ready handshake carrying data plus byte strobes.
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic [STRB_WIDTH-1:0] strb;

  modport source (output valid, output data, output strb, input ready);
  modport sink   (input valid, input data, input strb, output ready);
endinterface

// File: rtl/aes_block_packer.sv
// Gathers four 32-bit stream beats into one 128-bit AES block (first beat in the MSBs)
// and counts emitted blocks against a programmed job length.
//
// state   | meaning
// PK_IDLE | waiting for start
// PK_FILL | accepting beats into the block register
// PK_HOLD | block presented, waiting for the cipher core
// PK_DONE | one-cycle done pulse
module aes_block_packer
  import aes_block_packer_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  ctrl_packer_t           ctrl_i,
  output flags_packer_t          flags_o,
  hwpe_stream_intf_stream.sink   aes_input,
  output logic                   blk_valid_o,
  input  logic                   blk_ready_i,
  output logic [AES_BLK_W-1:0]   blk_data_o
);

  packer_state_t        r_state;
  logic [1:0]           r_idx;
  logic [AES_BLK_W-1:0] r_data;
  logic [N_BLK_W-1:0]   r_len;
  logic [N_BLK_W-1:0]   r_cnt;
  logic                 r_err;
  logic [N_BLK_W-1:0]   w_cnt_inc;

  assign w_cnt_inc = r_cnt + 1'b1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= PK_IDLE;
      r_idx   <= '0;
      r_data  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else if (clear_i) begin
      r_state <= PK_IDLE;
      r_idx   <= '0;
      r_data  <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        PK_IDLE: begin
          if (ctrl_i.start) begin
            if (ctrl_i.len_blocks != '0) begin
              r_len   <= ctrl_i.len_blocks;
              r_cnt   <= '0;
              r_idx   <= '0;
              r_err   <= 1'b0;
              r_state <= PK_FILL;
            end else begin
              r_state <= PK_DONE;
            end
          end
        end
        PK_FILL: begin
          if (aes_input.valid) begin
            case (r_idx)
              2'd0:    r_data[127:96] <= aes_input.data;
              2'd1:    r_data[95:64]  <= aes_input.data;
              2'd2:    r_data[63:32]  <= aes_input.data;
              default: r_data[31:0]   <= aes_input.data;
            endcase
            // Partial strobes are flagged but the word is kept as delivered.
            if (aes_input.strb != 4'hF) r_err <= 1'b1;
            r_idx <= r_idx + 2'd1;
            if (r_idx == 2'd3) r_state <= PK_HOLD;
          end
        end
        PK_HOLD: begin
          if (blk_ready_i) begin
            r_cnt   <= w_cnt_inc;
            r_state <= (w_cnt_inc == r_len) ? PK_DONE : PK_FILL;
          end
        end
        default: r_state <= PK_IDLE;
      endcase
    end
  end

  assign aes_input.ready = (r_state == PK_FILL);
  assign blk_valid_o     = (r_state == PK_HOLD);
  assign blk_data_o      = r_data;

  assign flags_o = '{busy:     (r_state != PK_IDLE),
                     done:     (r_state == PK_DONE),
                     err_strb: r_err,
                     blk_cnt:  r_cnt};

endmodule

// File: tb/tb_aes_block_packer.sv
// Directed and random-stall bench for aes_block_packer.
module tb_aes_block_packer;
  import aes_block_packer_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear;
  ctrl_packer_t  ctrl;
  flags_packer_t flags;
  logic          blk_valid;
  logic          blk_ready;
  logic [127:0]  blk_data;

  int n_cmp = 0;
  int n_err = 0;

  hwpe_stream_intf_stream #(.DATA_WIDTH(32)) aes_input ();

  always #5 clk = ~clk;

  aes_block_packer dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .clear_i     (clear),
    .ctrl_i      (ctrl),
    .flags_o     (flags),
    .aes_input   (aes_input),
    .blk_valid_o (blk_valid),
    .blk_ready_i (blk_ready),
    .blk_data_o  (blk_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [15:0] len);
    ctrl.start      = 1'b1;
    ctrl.len_blocks = len;
    tick();
    ctrl.start = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] s);
    int budget = 0;
    aes_input.valid = 1'b1;
    aes_input.data  = d;
    aes_input.strb  = s;
    while (!aes_input.ready && budget < 50) begin
      tick();
      budget++;
    end
    n_cmp++;
    if (aes_input.ready !== 1'b1) begin
      n_err++;
      $display("FAIL beat_wait_timeout: ready=%b required 1", aes_input.ready);
    end
    tick();
    aes_input.valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear = 1'b0;
    ctrl  = '0;
    blk_ready = 1'b0;
    aes_input.valid = 1'b0;
    aes_input.data  = '0;
    aes_input.strb  = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (flags !== '0) begin n_err++; $display("FAIL reset_flags: got %h want 0", flags); end
    n_cmp++; if (blk_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", blk_valid); end
    n_cmp++; if (blk_data !== '0) begin n_err++; $display("FAIL reset_data: got %h want 0", blk_data); end
    n_cmp++; if (aes_input.ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", aes_input.ready); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    blk_ready = 1'b1;
    pulse_start(16'd1);
    n_cmp++; if (aes_input.ready !== 1'b1) begin n_err++; $display("FAIL basic_ready: got %b want 1", aes_input.ready); end
    n_cmp++; if (flags.busy !== 1'b1) begin n_err++; $display("FAIL basic_busy: got %b want 1", flags.busy); end
    send_beat(32'h00112233, 4'hF);
    send_beat(32'h44556677, 4'hF);
    send_beat(32'h8899AABB, 4'hF);
    send_beat(32'hCCDDEEFF, 4'hF);
    n_cmp++; if (blk_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %b want 1", blk_valid); end
    n_cmp++; if (aes_input.ready !== 1'b0) begin n_err++; $display("FAIL basic_ready_hold: got %b want 0", aes_input.ready); end
    n_cmp++;
    if (blk_data !== 128'h00112233_44556677_8899AABB_CCDDEEFF) begin
      n_err++; $display("FAIL basic_data: got %h want 00112233445566778899aabbccddeeff", blk_data);
    end
    tick();
    n_cmp++; if (flags.done !== 1'b1) begin n_err++; $display("FAIL basic_done: got %b want 1", flags.done); end
    n_cmp++; if (flags.blk_cnt !== 16'd1) begin n_err++; $display("FAIL basic_cnt: got %0d want 1", flags.blk_cnt); end
    n_cmp++; if (blk_valid !== 1'b0) begin n_err++; $display("FAIL basic_valid_drop: got %b want 0", blk_valid); end
    tick();
    n_cmp++; if (flags.done !== 1'b0) begin n_err++; $display("FAIL basic_done_width: got %b want 0", flags.done); end
    n_cmp++; if (flags.busy !== 1'b0) begin n_err++; $display("FAIL basic_idle: got %b want 0", flags.busy); end
    n_cmp++; if (flags.blk_cnt !== 16'd1) begin n_err++; $display("FAIL basic_cnt_hold: got %0d want 1", flags.blk_cnt); end
  endtask

  task automatic test_backpressure();
    logic [127:0] exp1;
    exp1 = 128'hA0A1A2A3_B0B1B2B3_C0C1C2C3_D0D1D2D3;
    blk_ready = 1'b0;
    pulse_start(16'd2);
    send_beat(32'hA0A1A2A3, 4'hF);
    send_beat(32'hB0B1B2B3, 4'hF);
    send_beat(32'hC0C1C2C3, 4'hF);
    send_beat(32'hD0D1D2D3, 4'hF);
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if (blk_valid !== 1'b1 || aes_input.ready !== 1'b0 || blk_data !== exp1) begin
        n_err++;
        $display("FAIL bp_stall[%0d]: valid=%b ready=%b data=%h want valid=1 ready=0 data=%h",
                 i, blk_valid, aes_input.ready, blk_data, exp1);
      end
      tick();
    end
    blk_ready = 1'b1;
    tick();
    n_cmp++; if (flags.blk_cnt !== 16'd1) begin n_err++; $display("FAIL bp_cnt1: got %0d want 1", flags.blk_cnt); end
    n_cmp++; if (aes_input.ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_back: got %b want 1", aes_input.ready); end
    n_cmp++; if (flags.done !== 1'b0) begin n_err++; $display("FAIL bp_early_done: got %b want 0", flags.done); end
    send_beat(32'h10203040, 4'hF);
    send_beat(32'h50607080, 4'hF);
    send_beat(32'h90A0B0C0, 4'hF);
    send_beat(32'hD0E0F001, 4'hF);
    n_cmp++;
    if (blk_data !== 128'h10203040_50607080_90A0B0C0_D0E0F001) begin
      n_err++; $display("FAIL bp_data2: got %h want 102030405060708090a0b0c0d0e0f001", blk_data);
    end
    tick();
    n_cmp++; if (flags.done !== 1'b1) begin n_err++; $display("FAIL bp_done: got %b want 1", flags.done); end
    n_cmp++; if (flags.blk_cnt !== 16'd2) begin n_err++; $display("FAIL bp_cnt2: got %0d want 2", flags.blk_cnt); end
    tick();
    n_cmp++; if (flags.done !== 1'b0) begin n_err++; $display("FAIL bp_single_done: got %b want 0", flags.done); end
  endtask

  task automatic test_zero_len();
    pulse_start(16'd0);
    n_cmp++; if (flags.done !== 1'b1) begin n_err++; $display("FAIL zero_done: got %b want 1", flags.done); end
    n_cmp++; if (blk_valid !== 1'b0) begin n_err++; $display("FAIL zero_valid: got %b want 0", blk_valid); end
    n_cmp++; if (aes_input.ready !== 1'b0) begin n_err++; $display("FAIL zero_ready: got %b want 0", aes_input.ready); end
    tick();
    n_cmp++;
    if (flags.done !== 1'b0 || flags.busy !== 1'b0 || aes_input.ready !== 1'b0) begin
      n_err++; $display("FAIL zero_after: done=%b busy=%b ready=%b want 0 0 0", flags.done, flags.busy, aes_input.ready);
    end
  endtask

  task automatic test_bad_strobe();
    blk_ready = 1'b1;
    pulse_start(16'd1);
    send_beat(32'hDEADBEEF, 4'hF);
    send_beat(32'h01234567, 4'h7);
    n_cmp++; if (flags.err_strb !== 1'b1) begin n_err++; $display("FAIL strb_err_set: got %b want 1", flags.err_strb); end
    send_beat(32'h89ABCDEF, 4'hF);
    send_beat(32'h0F1E2D3C, 4'hF);
    n_cmp++;
    if (blk_data !== 128'hDEADBEEF_01234567_89ABCDEF_0F1E2D3C) begin
      n_err++; $display("FAIL strb_data: got %h want deadbeef0123456789abcdef0f1e2d3c", blk_data);
    end
    tick();
    n_cmp++; if (flags.done !== 1'b1) begin n_err++; $display("FAIL strb_done: got %b want 1", flags.done); end
    ctrl.start      = 1'b1;
    ctrl.len_blocks = 16'd1;
    tick();
    ctrl.start = 1'b0;
    n_cmp++; if (flags.busy !== 1'b0) begin n_err++; $display("FAIL start_on_done_ignored: busy=%b want 0", flags.busy); end
    n_cmp++; if (flags.err_strb !== 1'b1) begin n_err++; $display("FAIL strb_sticky: got %b want 1", flags.err_strb); end
    pulse_start(16'd1);
    n_cmp++; if (flags.busy !== 1'b1) begin n_err++; $display("FAIL start_after_done: busy=%b want 1", flags.busy); end
    n_cmp++; if (flags.err_strb !== 1'b0) begin n_err++; $display("FAIL strb_cleared_on_start: got %b want 0", flags.err_strb); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_clear();
    blk_ready = 1'b1;
    pulse_start(16'd2);
    send_beat(32'h11111111, 4'hF);
    send_beat(32'h22222222, 4'hF);
    send_beat(32'h33333333, 4'hF);
    send_beat(32'h44444444, 4'hF);
    tick();
    n_cmp++; if (flags.blk_cnt !== 16'd1) begin n_err++; $display("FAIL clr_pre_cnt: got %0d want 1", flags.blk_cnt); end
    send_beat(32'h55555555, 4'hF);
    send_beat(32'h66666666, 4'h3);
    aes_input.valid = 1'b1;
    aes_input.data  = 32'hBAD0BAD0;
    aes_input.strb  = 4'hF;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    aes_input.valid = 1'b0;
    n_cmp++;
    if (flags.busy !== 1'b0 || flags.blk_cnt !== 16'd0 || flags.err_strb !== 1'b0 || flags.done !== 1'b0) begin
      n_err++; $display("FAIL clr_flags: busy=%b cnt=%0d err=%b done=%b want 0 0 0 0",
                        flags.busy, flags.blk_cnt, flags.err_strb, flags.done);
    end
    n_cmp++; if (aes_input.ready !== 1'b0) begin n_err++; $display("FAIL clr_ready: got %b want 0", aes_input.ready); end
    tick();
    n_cmp++; if (flags.done !== 1'b0) begin n_err++; $display("FAIL clr_no_done: got %b want 0", flags.done); end
    pulse_start(16'd1);
    send_beat(32'hCAFE0001, 4'hF);
    send_beat(32'hCAFE0002, 4'hF);
    send_beat(32'hCAFE0003, 4'hF);
    send_beat(32'hCAFE0004, 4'hF);
    n_cmp++;
    if (blk_data !== 128'hCAFE0001_CAFE0002_CAFE0003_CAFE0004) begin
      n_err++; $display("FAIL clr_new_block: got %h want cafe0001cafe0002cafe0003cafe0004", blk_data);
    end
    tick();
    n_cmp++;
    if (flags.done !== 1'b1 || flags.blk_cnt !== 16'd1) begin
      n_err++; $display("FAIL clr_new_done: done=%b cnt=%0d want 1 1", flags.done, flags.blk_cnt);
    end
    tick();
  endtask

  task automatic test_async_reset();
    blk_ready = 1'b0;
    pulse_start(16'd1);
    send_beat(32'h12345678, 4'hF);
    send_beat(32'h9ABCDEF0, 4'hF);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (flags !== '0 || blk_valid !== 1'b0 || aes_input.ready !== 1'b0 || blk_data !== '0) begin
      n_err++; $display("FAIL async_reset: flags=%h valid=%b ready=%b data=%h want all 0",
                        flags, blk_valid, aes_input.ready, blk_data);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_soak();
    logic [127:0] exp_q[$];
    logic [127:0] acc;
    logic [127:0] exp_blk;
    int  beat_n = 0;
    int  blocks = 0;
    int  dones  = 0;
    logic in_hs, blk_hs;
    acc = '0;
    blk_ready = 1'b0;
    pulse_start(16'd100);
    for (int cyc = 0; cyc < 5000; cyc++) begin
      aes_input.valid = 1'($urandom_range(0, 1));
      aes_input.data  = $urandom;
      aes_input.strb  = 4'hF;
      blk_ready       = 1'($urandom_range(0, 1));
      ctrl.start      = flags.busy && ($urandom_range(0, 3) == 0);
      ctrl.len_blocks = 16'd3;
      in_hs  = aes_input.valid && aes_input.ready;
      blk_hs = blk_valid && blk_ready;
      if (blk_hs) begin
        blocks++;
        exp_blk = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hX;
        n_cmp++;
        if (blk_data !== exp_blk) begin
          n_err++; $display("FAIL soak_block[%0d]: got %h want %h", blocks, blk_data, exp_blk);
        end
      end
      if (in_hs) begin
        acc = {acc[95:0], aes_input.data};
        beat_n++;
        if (beat_n == 4) begin
          exp_q.push_back(acc);
          beat_n = 0;
        end
      end
      tick();
      if (flags.done) begin
        dones++;
        break;
      end
    end
    ctrl.start      = 1'b0;
    aes_input.valid = 1'b0;
    blk_ready       = 1'b0;
    n_cmp++; if (dones !== 1) begin n_err++; $display("FAIL soak_done_seen: got %0d want 1", dones); end
    n_cmp++; if (blocks !== 100) begin n_err++; $display("FAIL soak_blocks: got %0d want 100", blocks); end
    n_cmp++; if (flags.blk_cnt !== 16'd100) begin n_err++; $display("FAIL soak_cnt: got %0d want 100", flags.blk_cnt); end
    n_cmp++; if (flags.err_strb !== 1'b0) begin n_err++; $display("FAIL soak_err: got %b want 0", flags.err_strb); end
    tick();
    n_cmp++;
    if (flags.done !== 1'b0 || flags.busy !== 1'b0) begin
      n_err++; $display("FAIL soak_end: done=%b busy=%b want 0 0", flags.done, flags.busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_len();
    test_bad_strobe();
    test_clear();
    test_async_reset();
    test_soak();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
